// File: rtl/usr_pkg.sv
// ============================================================================
// Module      : usr_pkg
// Description : Shared mode encodings and sequencer states for the universal
//               shift register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usr_pkg;

    // The bit-cell mux select uses the same encoding as the manual mode input.
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } seq_state_e;

endpackage : usr_pkg

`default_nettype wire

// File: rtl/usr_bit_cell.sv
// ============================================================================
// Module      : usr_bit_cell
// Description : One register bit with a hold / right-shift / left-shift /
//               load next-value mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usr_bit_cell
    import usr_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  mode_e i_sel,
    input  logic  i_from_hi,
    input  logic  i_from_lo,
    input  logic  i_load,
    output logic  o_q
);

    logic r_q;

    // A right shift pulls from the next-higher bit; a left shift from the next-lower.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else begin
            case (i_sel)
                MODE_HOLD: r_q <= r_q;
                MODE_SHR:  r_q <= i_from_hi;
                MODE_SHL:  r_q <= i_from_lo;
                MODE_LOAD: r_q <= i_load;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule : usr_bit_cell

`default_nettype wire

// File: rtl/universal_shift_reg.sv
// ============================================================================
// Module      : universal_shift_reg
// Description : WIDTH-bit universal shift register with a built-in MSB-first
//               serialiser sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             rot,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    input  logic             start,
    output logic [WIDTH-1:0] pout,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  C_ONE  = CW'(1);

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_done;
    logic             w_done_nxt;
    mode_e            w_sel;
    logic [WIDTH-1:0] w_q;
    logic             w_fill_shr;
    logic             w_fill_shl;

    // Rotation recirculates the bit that falls off the opposite end.
    assign w_fill_shr = rot ? w_q[0]       : sin_l;
    assign w_fill_shl = rot ? w_q[WIDTH-1] : sin_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // The done cycle blocks start, which forces a gap between transfers.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = r_done;
        w_sel       = MODE_HOLD;
        if (en) begin
            w_done_nxt = 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !r_done) begin
                        w_sel       = MODE_LOAD;
                        w_state_nxt = SHIFT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_sel = mode_e'(mode);
                    end
                end
                SHIFT: begin
                    w_sel = MODE_SHL;
                    if (r_cnt == C_LAST) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + C_ONE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic w_from_hi;
        logic w_from_lo;

        if (i == WIDTH - 1) begin : g_top_edge
            assign w_from_hi = w_fill_shr;
        end else begin : g_top_inner
            assign w_from_hi = w_q[i+1];
        end

        if (i == 0) begin : g_bot_edge
            assign w_from_lo = w_fill_shl;
        end else begin : g_bot_inner
            assign w_from_lo = w_q[i-1];
        end

        usr_bit_cell u_cell (
            .clk       (clk),
            .rst_n     (reset),
            .i_sel     (w_sel),
            .i_from_hi (w_from_hi),
            .i_from_lo (w_from_lo),
            .i_load    (pin[i]),
            .o_q       (w_q[i])
        );
    end

    assign pout     = w_q;
    assign sout_msb = w_q[WIDTH-1];
    assign sout_lsb = w_q[0];
    assign busy     = (r_state == SHIFT);
    assign done     = r_done;

endmodule : universal_shift_reg

`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
// ============================================================================
// Module      : tb_universal_shift_reg
// Description : Directed self-checking bench for universal_shift_reg (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_universal_shift_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic       rot;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] pin;
    logic       start;
    logic [7:0] pout;
    logic       sout_msb;
    logic       sout_lsb;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        logic [7:0] p;
        logic       b;
        logic       d;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .rot      (rot),
        .sin_r    (sin_r),
        .sin_l    (sin_l),
        .pin      (pin),
        .start    (start),
        .pout     (pout),
        .sout_msb (sout_msb),
        .sout_lsb (sout_lsb),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(string tag, logic [7:0] p, logic b, logic d);
        exp_t e;
        e.tag = tag;
        e.p   = p;
        e.b   = b;
        e.d   = d;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".pout"}, pout, e.p);
            chk({e.tag, ".busy"}, {7'd0, busy}, {7'd0, e.b});
            chk({e.tag, ".done"}, {7'd0, done}, {7'd0, e.d});
            chk({e.tag, ".msb"},  {7'd0, sout_msb}, {7'd0, e.p[7]});
            chk({e.tag, ".lsb"},  {7'd0, sout_lsb}, {7'd0, e.p[0]});
        end
    endtask

    task automatic step(string tag, logic [7:0] p, logic b, logic d);
        push(tag, p, b, d);
        @(posedge clk);
        @(negedge clk);
        drain();
    endtask

    // Full serialise of w, optionally dropping en for gap_len edges before bit gap_at+1.
    task automatic ser(string tag, logic [7:0] w, int gap_at, int gap_len);
        logic [7:0] s;
        int         nbusy;
        pin   = w;
        start = 1'b1;
        mode  = 2'b00;
        en    = 1'b1;
        step($sformatf("%s_e0", tag), w, 1'b1, 1'b0);
        s     = {7'd0, sout_msb};
        nbusy = 32'(busy);
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == gap_at) begin
                en = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    step($sformatf("%s_gap%0d", tag, g), w << (k - 1), 1'b1, 1'b0);
                    nbusy += 32'(busy);
                end
                en = 1'b1;
            end
            mode = k[0] ? 2'b01 : 2'b11;
            if (k < 8) begin
                step($sformatf("%s_k%0d", tag, k), w << k, 1'b1, 1'b0);
                s = {s[6:0], sout_msb};
                nbusy += 32'(busy);
            end else begin
                step($sformatf("%s_done", tag), 8'h00, 1'b0, 1'b1);
            end
        end
        mode = 2'b00;
        chk($sformatf("%s_stream", tag), s, w);
        chk($sformatf("%s_busycnt", tag), 8'(nbusy), 8'(8 + gap_len));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        en    = 1'b1;
        mode  = 2'b11;
        rot   = 1'b0;
        sin_r = 1'b0;
        sin_l = 1'b0;
        pin   = 8'hA5;
        start = 1'b0;
        #1;
        push("rst_imm", 8'h00, 1'b0, 1'b0);
        drain();
        @(negedge clk);
        step("rst_hold0", 8'h00, 1'b0, 1'b0);
        step("rst_hold1", 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        mode  = 2'b00;
        step("rst_rel", 8'h00, 1'b0, 1'b0);

        mode = 2'b11; pin = 8'hB4;
        step("load_b4", 8'hB4, 1'b0, 1'b0);
        mode = 2'b01; sin_l = 1'b1;
        step("shr_fill1", 8'hDA, 1'b0, 1'b0);
        mode = 2'b10; rot = 1'b1;
        step("rotl", 8'hB5, 1'b0, 1'b0);
        mode = 2'b00; rot = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("hold%0d", i), 8'hB5, 1'b0, 1'b0);
        mode = 2'b10; sin_r = 1'b1;
        step("shl_fill1", 8'h6B, 1'b0, 1'b0);
        mode = 2'b01; rot = 1'b1;
        step("rotr", 8'hB5, 1'b0, 1'b0);
        mode = 2'b00; rot = 1'b0; sin_r = 1'b0;

        ser("c3", 8'hC3, 0, 0);
        step("c3_after", 8'h00, 1'b0, 1'b0);

        ser("f0", 8'hF0, 3, 3);
        en = 1'b0;
        step("done_frz0", 8'h00, 1'b0, 1'b1);
        step("done_frz1", 8'h00, 1'b0, 1'b1);
        en = 1'b1;
        step("done_clr", 8'h00, 1'b0, 1'b0);

        pin = 8'hA5; start = 1'b1;
        step("rm_e0", 8'hA5, 1'b1, 1'b0);
        start = 1'b0;
        for (int k = 1; k <= 3; k++) step($sformatf("rm_k%0d", k), 8'hA5 << k, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        push("rm_async", 8'h00, 1'b0, 1'b0);
        drain();
        @(negedge clk);
        step("rm_low0", 8'h00, 1'b0, 1'b0);
        step("rm_low1", 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        ser("x81", 8'h81, 0, 0);
        step("x81_after", 8'h00, 1'b0, 1'b0);

        pin = 8'h3C; mode = 2'b10; start = 1'b1;
        step("col_e0", 8'h3C, 1'b1, 1'b0);
        mode = 2'b00;
        for (int k = 1; k <= 7; k++) step($sformatf("col_k%0d", k), 8'h3C << k, 1'b1, 1'b0);
        step("col_done", 8'h00, 1'b0, 1'b1);
        step("col_ignored", 8'h00, 1'b0, 1'b0);
        step("col_second", 8'h3C, 1'b1, 1'b0);
        start = 1'b0;
        for (int k = 1; k <= 7; k++) step($sformatf("col2_k%0d", k), 8'h3C << k, 1'b1, 1'b0);
        step("col2_done", 8'h00, 1'b0, 1'b1);
        step("col2_after", 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_universal_shift_reg

`default_nettype wire
